// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants, sync-polarity encodings and elaboration helpers.
package vga_timing_pkg;

  typedef enum logic {
    PolActiveLow  = 1'b0,
    PolActiveHigh = 1'b1
  } syncPol_e;

  typedef struct packed {
    int unsigned hActive;
    int unsigned hFp;
    int unsigned hSync;
    int unsigned hBp;
    int unsigned vActive;
    int unsigned vFp;
    int unsigned vSync;
    int unsigned vBp;
    syncPol_e    hPol;
    syncPol_e    vPol;
  } vgaMode_t;

  localparam vgaMode_t MODE_640X480_60 = '{
    hActive: 640, hFp: 16, hSync: 96, hBp: 48,
    vActive: 480, vFp: 10, vSync: 2, vBp: 33,
    hPol: PolActiveLow, vPol: PolActiveLow
  };

  localparam vgaMode_t MODE_800X600_60 = '{
    hActive: 800, hFp: 40, hSync: 128, hBp: 88,
    vActive: 600, vFp: 1, vSync: 4, vBp: 23,
    hPol: PolActiveHigh, vPol: PolActiveHigh
  };

  localparam vgaMode_t MODE_1024X768_60 = '{
    hActive: 1024, hFp: 24, hSync: 136, hBp: 160,
    vActive: 768, vFp: 3, vSync: 6, vBp: 29,
    hPol: PolActiveLow, vPol: PolActiveLow
  };

  // True when an unsigned counter of the given width can represent value.
  function automatic bit fitsIn(int unsigned value, int unsigned width);
    if (width >= 32) return 1'b1;
    return value < (32'd1 << width);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with async active-low reset; zero depth is a plain wire.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : genWire
    logic unusedSigs;
    assign unusedSigs = ^{clk, rst, en};
    assign q = d;
  end else begin : genRegs
    logic [WIDTH-1:0] stageQ [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < int'(DEPTH); i++) stageQ[i] <= '0;
      end else if (en) begin
        stageQ[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stageQ[i] <= stageQ[i-1];
      end
    end

    assign q = stageQ[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: H/V counters, sync/de generation and a
// latency-matched pixel pipeline, all advancing on the pixel-clock enable.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned COLOR_W   = 3,
  parameter int unsigned H_ACTIVE  = MODE_640X480_60.hActive,
  parameter int unsigned H_FP      = MODE_640X480_60.hFp,
  parameter int unsigned H_SYNC    = MODE_640X480_60.hSync,
  parameter int unsigned H_BP      = MODE_640X480_60.hBp,
  parameter int unsigned V_ACTIVE  = MODE_640X480_60.vActive,
  parameter int unsigned V_FP      = MODE_640X480_60.vFp,
  parameter int unsigned V_SYNC    = MODE_640X480_60.vSync,
  parameter int unsigned V_BP      = MODE_640X480_60.vBp,
  parameter int unsigned HSYNC_POL = 0,
  parameter int unsigned VSYNC_POL = 0,
  parameter int unsigned PIX_LAT   = 1,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic [COLOR_W-1:0] pixel_in,
  output logic [COLOR_W-1:0] pixel_out,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [X_W-1:0]     pos_x,
  output logic [Y_W-1:0]     pos_y,
  output logic               active,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [X_W-1:0] X_LAST  = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_TOTAL - 1);
  localparam logic           HS_ON   = (HSYNC_POL != 0);
  localparam logic           HS_IDLE = !(HSYNC_POL != 0);
  localparam logic           VS_ON   = (VSYNC_POL != 0);
  localparam logic           VS_IDLE = !(VSYNC_POL != 0);

  if (!fitsIn(H_TOTAL - 1, X_W)) begin : genXwCheck
    $error("X_W too narrow for H_TOTAL-1");
  end
  if (!fitsIn(V_TOTAL - 1, Y_W)) begin : genYwCheck
    $error("Y_W too narrow for V_TOTAL-1");
  end
  if (PIX_LAT > 4) begin : genLatCheck
    $error("PIX_LAT must be in 0..4");
  end

  logic [X_W-1:0] xQ, xD;
  logic [Y_W-1:0] yQ, yD;

  always_comb begin
    xD = xQ;
    yD = yQ;
    if (pix_en) begin
      if (xQ == X_LAST) begin
        xD = '0;
        yD = (yQ == Y_LAST) ? '0 : yQ + Y_W'(1);
      end else begin
        xD = xQ + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xQ <= '0;
      yQ <= '0;
    end else begin
      xQ <= xD;
      yQ <= yD;
    end
  end

  // Raw timing is decoded from the counters; y only moves on the x wrap, so
  // vs_raw is inherently line-synchronous.
  int unsigned xPix, yPix;
  logic        deRaw, hsRaw, vsRaw;

  always_comb begin
    xPix  = 32'(xQ);
    yPix  = 32'(yQ);
    deRaw = (xPix < H_ACTIVE) && (yPix < V_ACTIVE);
    hsRaw = (xPix >= HS_START) && (xPix < HS_END);
    vsRaw = (yPix >= VS_START) && (yPix < VS_END);
  end

  logic [2:0] dlyBits;

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIX_LAT)
  ) uDelay (
    .clk (clk),
    .rst (rst),
    .en  (pix_en),
    .d   ({deRaw, hsRaw, vsRaw}),
    .q   (dlyBits)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_out <= '0;
      de        <= 1'b0;
      hsync     <= HS_IDLE;
      vsync     <= VS_IDLE;
    end else if (pix_en) begin
      pixel_out <= dlyBits[2] ? pixel_in : '0;
      de        <= dlyBits[2];
      hsync     <= dlyBits[1] ? HS_ON : HS_IDLE;
      vsync     <= dlyBits[0] ? VS_ON : VS_IDLE;
    end
  end

  // Strobes are gated by reset so they stay low while the block is held.
  always_comb begin
    pos_x       = xQ;
    pos_y       = yQ;
    active      = deRaw;
    line_start  = rst && pix_en && (xQ == '0);
    frame_start = rst && pix_en && (xQ == '0) && (yQ == '0);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench: four timing generators checked every cycle against a
// position-index model (tick count -> x/y via div/mod), plus literal pins.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: small mode, PIX_LAT=2, random enable. B: small mode, PIX_LAT=0,
  // active-high syncs, enable every other clk. C: default 640x480. D: 800x600.
  logic       enA = 1'b1, enB = 1'b1, enC = 1'b1, enD = 1'b1;
  logic [2:0] pixA = '0, pixB, pixC = '0, pixD = '0;
  logic [2:0] pxA, pxB, pxC, pxD;
  logic       hsA, hsB, hsC, hsD, vsA, vsB, vsC, vsD, deA, deB, deC, deD;
  logic       acA, acB, acC, acD, lsA, lsB, lsC, lsD, fsA, fsB, fsC, fsD;
  logic [4:0] posXA;  logic [3:0] posYA;
  logic [3:0] posXB;  logic [2:0] posYB;
  logic [9:0] posXC;  logic [9:0] posYC;
  logic [10:0] posXD; logic [9:0] posYD;
  longint tA = 0, tB = 0, tC = 0, tD = 0;

  function automatic logic [2:0] colorAt(int x, int y, int ha, int va);
    if (x < ha && y < va) return 3'(x ^ (y << 1));
    return 3'b111;
  endfunction

  function automatic logic [2:0] pixFor(longint t, int lat, int ht, int vt, int ha, int va);
    longint idx;
    if (t < longint'(lat)) return 3'($urandom);
    idx = t - lat;
    return colorAt(int'(idx % ht), int'((idx / ht) % vt), ha, va);
  endfunction

  assign pixB = colorAt(int'(posXB), int'(posYB), 8, 4);

  vga_timing_gen #(.COLOR_W(3), .H_ACTIVE(12), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .HSYNC_POL(0), .VSYNC_POL(0),
    .PIX_LAT(2), .X_W(5), .Y_W(4)) dutA (
    .clk(clk), .rst(rst), .pix_en(enA), .pixel_in(pixA), .pixel_out(pxA), .hsync(hsA),
    .vsync(vsA), .de(deA), .pos_x(posXA), .pos_y(posYA), .active(acA),
    .line_start(lsA), .frame_start(fsA));

  vga_timing_gen #(.COLOR_W(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .HSYNC_POL(1), .VSYNC_POL(1),
    .PIX_LAT(0), .X_W(4), .Y_W(3)) dutB (
    .clk(clk), .rst(rst), .pix_en(enB), .pixel_in(pixB), .pixel_out(pxB), .hsync(hsB),
    .vsync(vsB), .de(deB), .pos_x(posXB), .pos_y(posYB), .active(acB),
    .line_start(lsB), .frame_start(fsB));

  vga_timing_gen dutC (
    .clk(clk), .rst(rst), .pix_en(enC), .pixel_in(pixC), .pixel_out(pxC), .hsync(hsC),
    .vsync(vsC), .de(deC), .pos_x(posXC), .pos_y(posYC), .active(acC),
    .line_start(lsC), .frame_start(fsC));

  vga_timing_gen #(.COLOR_W(3), .H_ACTIVE(MODE_800X600_60.hActive),
    .H_FP(MODE_800X600_60.hFp), .H_SYNC(MODE_800X600_60.hSync), .H_BP(MODE_800X600_60.hBp),
    .V_ACTIVE(MODE_800X600_60.vActive), .V_FP(MODE_800X600_60.vFp),
    .V_SYNC(MODE_800X600_60.vSync), .V_BP(MODE_800X600_60.vBp), .HSYNC_POL(1),
    .VSYNC_POL(1), .PIX_LAT(1), .X_W(11), .Y_W(10)) dutD (
    .clk(clk), .rst(rst), .pix_en(enD), .pixel_in(pixD), .pixel_out(pxD), .hsync(hsD),
    .vsync(vsD), .de(deD), .pos_x(posXD), .pos_y(posYD), .active(acD),
    .line_start(lsD), .frame_start(fsD));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic checkDut(input string nm, input longint t, input int en, input int lat,
                          input int ha, input int hf, input int hs, input int hb,
                          input int va, input int vf, input int vs, input int vb,
                          input int hp, input int vp, input int ax, input int ay,
                          input int aAct, input int aLs, input int aFs, input int aDe,
                          input int aHs, input int aVs, input int aPix);
    int ht, vt, x, y, ix, iy, eDe, eHs, eVs, ePix;
    longint idx;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    x  = int'(t % ht);
    y  = int'((t / ht) % vt);
    chk({nm, " pos_x"}, ax, x);
    chk({nm, " pos_y"}, ay, y);
    chk({nm, " active"}, aAct, int'(x < ha && y < va));
    chk({nm, " line_start"}, aLs, int'(en != 0 && x == 0));
    chk({nm, " frame_start"}, aFs, int'(en != 0 && x == 0 && y == 0));
    eDe = 0; eHs = 0; eVs = 0; ePix = 0;
    idx = t - 1 - lat;
    if (idx >= 0) begin
      ix  = int'(idx % ht);
      iy  = int'((idx / ht) % vt);
      eDe = int'(ix < ha && iy < va);
      eHs = int'(ix >= ha + hf && ix < ha + hf + hs);
      eVs = int'(iy >= va + vf && iy < va + vf + vs);
      if (eDe != 0) ePix = int'(colorAt(ix, iy, ha, va));
    end
    chk({nm, " de"}, aDe, eDe);
    chk({nm, " hsync"}, aHs, (eHs != 0) ? hp : 1 - hp);
    chk({nm, " vsync"}, aVs, (eVs != 0) ? vp : 1 - vp);
    chk({nm, " pixel_out"}, aPix, ePix);
  endtask

  task automatic checkReset(input string nm, input int ax, input int ay, input int aDe,
                            input int aPix, input int aHs, input int aVs, input int aLs,
                            input int aFs, input int idleLvl);
    chk({nm, " rst pos_x"}, ax, 0);
    chk({nm, " rst pos_y"}, ay, 0);
    chk({nm, " rst de"}, aDe, 0);
    chk({nm, " rst pixel_out"}, aPix, 0);
    chk({nm, " rst hsync"}, aHs, idleLvl);
    chk({nm, " rst vsync"}, aVs, idleLvl);
    chk({nm, " rst line_start"}, aLs, 0);
    chk({nm, " rst frame_start"}, aFs, 0);
  endtask

  task automatic checkAllReset();
    checkReset("A", int'(posXA), int'(posYA), int'(deA), int'(pxA), int'(hsA), int'(vsA),
               int'(lsA), int'(fsA), 1);
    checkReset("B", int'(posXB), int'(posYB), int'(deB), int'(pxB), int'(hsB), int'(vsB),
               int'(lsB), int'(fsB), 0);
    checkReset("C", int'(posXC), int'(posYC), int'(deC), int'(pxC), int'(hsC), int'(vsC),
               int'(lsC), int'(fsC), 1);
    checkReset("D", int'(posXD), int'(posYD), int'(deD), int'(pxD), int'(hsD), int'(vsD),
               int'(lsD), int'(fsD), 0);
  endtask

  task automatic drive();
    @(posedge clk);
    if (rst) begin
      if (enA) tA++;
      if (enB) tB++;
      if (enC) tC++;
      if (enD) tD++;
    end
    #1;
    enA  = ($urandom_range(0, 3) != 0);
    enB  = !enB;
    pixA = pixFor(tA, 2, 24, 13, 12, 6);
    pixC = pixFor(tC, 1, 800, 525, 640, 480);
    pixD = pixFor(tD, 1, 1056, 628, 800, 600);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      checkDut("A", tA, int'(enA), 2, 12, 3, 4, 5, 6, 2, 2, 3, 0, 0,
               int'(posXA), int'(posYA), int'(acA), int'(lsA), int'(fsA), int'(deA),
               int'(hsA), int'(vsA), int'(pxA));
      checkDut("B", tB, int'(enB), 0, 8, 2, 3, 1, 4, 1, 1, 2, 1, 1,
               int'(posXB), int'(posYB), int'(acB), int'(lsB), int'(fsB), int'(deB),
               int'(hsB), int'(vsB), int'(pxB));
      checkDut("C", tC, int'(enC), 1, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0,
               int'(posXC), int'(posYC), int'(acC), int'(lsC), int'(fsC), int'(deC),
               int'(hsC), int'(vsC), int'(pxC));
      checkDut("D", tD, int'(enD), 1, 800, 40, 128, 88, 600, 1, 4, 23, 1, 1,
               int'(posXD), int'(posYD), int'(acD), int'(lsD), int'(fsD), int'(deD),
               int'(hsD), int'(vsD), int'(pxD));
      // Hand-derived points: position k is visible after k+PIX_LAT+1 ticks.
      if (tC == 1)    chk("C lit de before first pixel", int'(deC), 0);
      if (tC == 2)    chk("C lit de first pixel", int'(deC), 1);
      if (tC == 641)  chk("C lit de last pixel", int'(deC), 1);
      if (tC == 642)  chk("C lit de after line", int'(deC), 0);
      if (tC == 657)  chk("C lit hsync before pulse", int'(hsC), 1);
      if (tC == 658)  chk("C lit hsync pulse start", int'(hsC), 0);
      if (tC == 753)  chk("C lit hsync pulse end", int'(hsC), 0);
      if (tC == 754)  chk("C lit hsync after pulse", int'(hsC), 1);
      if (tC == 800)  chk("C lit line_start line 1", int'(lsC), 1);
      if (tC == 800)  chk("C lit pos_y line 1", int'(posYC), 1);
      if (tC == 841)  chk("D lit hsync before pulse", int'(hsD), 0);
      if (tC == 842)  chk("D lit hsync pulse start", int'(hsD), 1);
      if (tD == 969)  chk("D lit hsync pulse end", int'(hsD), 1);
      if (tD == 970)  chk("D lit hsync after pulse", int'(hsD), 0);
      if (tD == 1055) chk("D lit pos_x last", int'(posXD), 1055);
      if (tD == 1056) chk("D lit pos_x wrap", int'(posXD), 0);
      if (tD == 1056) chk("D lit pos_y line 1", int'(posYD), 1);
    end
  end

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 checkAllReset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4013) drive();
    // Asynchronous reset mid-line with pix_en still high: outputs clear at once.
    #2 rst = 1'b0;
    #1 checkAllReset();
    tA = 0; tB = 0; tC = 0; tD = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3000) drive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
